// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: swept-frequency sequencer for the DDS ROM address path.
// Optional: define DDS_SWEEP_LOOP_EN to repeat the sweep until abort.
module dds_sweep_ctrl #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 8,
  parameter int DWELL_W = 16
) (
  input  logic               clk_DDS,
  input  logic               Rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ACC_W-1:0]   cfg_start_fword,
  input  logic [ACC_W-1:0]   cfg_stop_fword,
  input  logic [ACC_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [8:0]         cfg_phase,
  input  logic               abort,
  output logic [ADDR_W-1:0]  Addr_Out,
  output logic [ACC_W-1:0]   cur_fword,
  output logic               busy,
  output logic               done
);
  localparam int PW = ADDR_W + 9;

  typedef enum logic [1:0] {
    IDLE, LOAD, SWEEP, DONE
  } state_t;

  state_t state, state_nx;

  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   fword;
  logic [ACC_W-1:0]   start_r;
  logic [ACC_W-1:0]   stop_r;
  logic [ACC_W-1:0]   step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [8:0]         phase_r;
  logic [8:0]         phase_c;
  logic [ADDR_W-1:0]  pword;
  logic [ACC_W:0]     fw_next;
  logic               take, ld, run;
  logic               expire, last;
  logic               adv, restart;

  assign expire  = (dwell_cnt == '0);
  assign last    = (fword == stop_r) ||
                   (start_r >= stop_r);
  // one extra bit so an overshoot past
  // the top of the word range still clamps
  assign fw_next = {1'b0, fword} +
                   {1'b0, step_r};
  assign phase_c = (phase_r > 9'd359) ?
                   9'd359 : phase_r;

  always_ff @(posedge clk_DDS) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    ld       = 1'b0;
    run      = 1'b0;
    adv      = 1'b0;
    restart  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_valid) begin
          state_nx = LOAD;
          take     = 1'b1;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          state_nx = SWEEP;
          ld       = 1'b1;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_nx = IDLE;
        end else begin
          run = 1'b1;
          if (expire && step_r != '0) begin
            if (!last) begin
              adv = 1'b1;
            end else begin
`ifdef DDS_SWEEP_LOOP_EN
              restart = 1'b1;
`else
              state_nx = DONE;
`endif
            end
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_DDS) begin
    if (!Rst) begin
      acc       <= '0;
      fword     <= '0;
      pword     <= '0;
      dwell_cnt <= '0;
      start_r   <= '0;
      stop_r    <= '0;
      step_r    <= '0;
      dwell_r   <= '0;
      phase_r   <= '0;
    end else begin
      if (take) begin
        start_r <= cfg_start_fword;
        stop_r  <= cfg_stop_fword;
        step_r  <= cfg_step;
        dwell_r <= (cfg_dwell == '0) ? '0 :
                   cfg_dwell - DWELL_W'(1);
        phase_r <= cfg_phase;
      end
      if (ld) begin
        acc       <= '0;
        fword     <= start_r;
        dwell_cnt <= dwell_r;
        pword     <= ADDR_W'(
          {phase_c, {ADDR_W{1'b0}}} /
          PW'(360));
      end
      if (run) begin
        acc       <= acc + fword;
        dwell_cnt <= expire ? dwell_r :
                     dwell_cnt - DWELL_W'(1);
        if (adv)
          fword <= (fw_next > {1'b0, stop_r}) ?
                   stop_r : fw_next[ACC_W-1:0];
        if (restart)
          fword <= start_r;
      end
    end
  end

  assign Addr_Out  = acc[ACC_W-1 -: ADDR_W] + pword;
  assign cur_fword = fword;
  assign busy      = (state == LOAD) ||
                     (state == SWEEP);
  assign done      = (state == DONE);
  assign cfg_ready = (state == IDLE);

endmodule
